// File: rtl/cnn_udiv_21ns_12ns_seq_pkg.sv
// Shared widths and state encoding for the sequential 21/12 unsigned divider.
package cnn_div_pkg;

    localparam int unsigned CNN_DIV_DIVIDEND_W = 21;
    localparam int unsigned CNN_DIV_DIVISOR_W  = 12;
    localparam int unsigned CNN_DIV_CNT_W      = $clog2(CNN_DIV_DIVIDEND_W);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_t;

endpackage

// File: rtl/cnn_udiv_21ns_12ns_seq_if.sv
// Operand/result handshake bundle between the MAC accumulator side and the divider.
interface cnn_udiv_21ns_12ns_seq_if;
    import cnn_div_pkg::*;

    logic                          in_valid;
    logic                          in_ready;
    logic [CNN_DIV_DIVIDEND_W-1:0] dividend;
    logic [CNN_DIV_DIVISOR_W-1:0]  divisor;
    logic                          out_valid;
    logic                          out_ready;
    logic [CNN_DIV_DIVIDEND_W-1:0] quotient;
    logic [CNN_DIV_DIVISOR_W-1:0]  remainder;
    logic                          div_by_zero;

    // Requester: issues operands, consumes results.
    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    // Divider: accepts operands, produces results.
    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/cnn_udiv_21ns_12ns_seq_step.sv
// One restoring-division step: shift in the next dividend bit, subtract if it fits.
module cnn_udiv_step #(
    parameter int unsigned DIVISOR_W = 12
) (
    input  logic [DIVISOR_W-1:0] part_rem,
    input  logic                 next_bit,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W-1:0] new_rem,
    output logic                 qbit
);

    logic [DIVISOR_W:0] trial;

    // Trial remainder is one bit wider; the result always fits back into DIVISOR_W bits.
    always_comb begin
        trial   = {part_rem, next_bit};
        qbit    = (trial >= {1'b0, divisor});
        new_rem = qbit ? DIVISOR_W'(trial - {1'b0, divisor}) : DIVISOR_W'(trial);
    end

endmodule

// File: rtl/cnn_udiv_21ns_12ns_seq.sv
// Sequential radix-2 restoring unsigned divider, 21-bit dividend by 12-bit divisor.
module cnn_udiv_21ns_12ns_seq
    import cnn_div_pkg::*;
(
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    cnn_udiv_21ns_12ns_seq_if.slave  div_if
);

    localparam int unsigned DW    = CNN_DIV_DIVIDEND_W;
    localparam int unsigned SW    = CNN_DIV_DIVISOR_W;
    localparam int unsigned CNT_W = CNN_DIV_CNT_W;

    div_state_t        state;
    logic [CNT_W-1:0]  count;
    // Dividend bits leave at the MSB while quotient bits enter at the LSB.
    logic [DW-1:0]     work;
    logic [SW-1:0]     dvs;
    logic [SW-1:0]     part_rem;

    logic              in_ready;
    logic              out_valid;
    logic [DW-1:0]     quotient;
    logic [SW-1:0]     remainder;
    logic              div_by_zero;

    logic [SW-1:0]     step_rem;
    logic              step_qbit;

    cnn_udiv_step #(.DIVISOR_W(SW)) u_step (
        .part_rem (part_rem),
        .next_bit (work[DW-1]),
        .divisor  (dvs),
        .new_rem  (step_rem),
        .qbit     (step_qbit)
    );

    // Control FSM, datapath shift registers and registered result/handshake outputs.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state       <= IDLE;
            count       <= '0;
            work        <= '0;
            dvs         <= '0;
            part_rem    <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (div_if.in_valid) begin
                        work     <= div_if.dividend;
                        dvs      <= div_if.divisor;
                        part_rem <= '0;
                        count    <= '0;
                        in_ready <= 1'b0;
                        if (div_if.divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= div_if.dividend[SW-1:0];
                            div_by_zero <= 1'b1;
                            out_valid   <= 1'b1;
                            state       <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    work     <= {work[DW-2:0], step_qbit};
                    part_rem <= step_rem;
                    count    <= count + CNT_W'(1);
                    if (count == CNT_W'(DW - 1)) begin
                        quotient    <= {work[DW-2:0], step_qbit};
                        remainder   <= step_rem;
                        div_by_zero <= 1'b0;
                        out_valid   <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (div_if.out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign div_if.in_ready    = in_ready;
    assign div_if.out_valid   = out_valid;
    assign div_if.quotient    = quotient;
    assign div_if.remainder   = remainder;
    assign div_if.div_by_zero = div_by_zero;

endmodule

// File: tb/tb_cnn_udiv_21ns_12ns_seq.sv
// Directed-vector and randomized scoreboard bench for the sequential divider.
module tb_cnn_udiv_21ns_12ns_seq;

    localparam int NRAND = 300;

    typedef struct {
        logic [20:0] a;
        logic [11:0] b;
        logic [20:0] q;
        logic [11:0] r;
        logic        z;
        int          lat;   // posedges after the accepting edge until out_valid is seen
    } vec_t;

    logic ap_clk = 1'b0;
    logic ap_rst_n;

    cnn_udiv_21ns_12ns_seq_if div_if ();

    cnn_udiv_21ns_12ns_seq dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .div_if   (div_if)
    );

    always #5 ap_clk = ~ap_clk;

    int n_cmp = 0;
    int n_err = 0;

    vec_t        vecs[12];
    logic [20:0] rq;
    logic [11:0] rr;
    logic        rz;
    int          rlat;

    logic [20:0] qa[$];
    logic [11:0] qb[$];
    int          sent;
    int          got;
    logic [20:0] ea;
    logic [11:0] eb;
    logic [20:0] eq;
    logic [11:0] er;
    logic        ez;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issue one operation with out_ready held high and collect its result.
    task automatic run_op(input logic [20:0] a, input logic [11:0] b,
                          output logic [20:0] q, output logic [11:0] r,
                          output logic z, output int lat);
        @(negedge ap_clk);
        div_if.in_valid  = 1'b1;
        div_if.dividend  = a;
        div_if.divisor   = b;
        div_if.out_ready = 1'b1;
        @(posedge ap_clk);
        #1;
        div_if.in_valid = 1'b0;
        lat = 0;
        while (!div_if.out_valid && lat < 100) begin
            @(posedge ap_clk);
            #1;
            lat++;
        end
        q = div_if.quotient;
        r = div_if.remainder;
        z = div_if.div_by_zero;
        @(posedge ap_clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{a: 21'd1000000, b: 12'd1000, q: 21'd1000,    r: 12'd0,    z: 1'b0, lat: 21};
        vecs[1]  = '{a: 21'd2097151, b: 12'd4095, q: 21'd512,     r: 12'd511,  z: 1'b0, lat: 21};
        vecs[2]  = '{a: 21'd5,       b: 12'd7,    q: 21'd0,       r: 12'd5,    z: 1'b0, lat: 21};
        vecs[3]  = '{a: 21'd4095,    b: 12'd1,    q: 21'd4095,    r: 12'd0,    z: 1'b0, lat: 21};
        vecs[4]  = '{a: 21'd1234,    b: 12'd0,    q: 21'h1FFFFF,  r: 12'd1234, z: 1'b1, lat: 0};
        vecs[5]  = '{a: 21'd100,     b: 12'd3,    q: 21'd33,      r: 12'd1,    z: 1'b0, lat: 21};
        vecs[6]  = '{a: 21'd300,     b: 12'd7,    q: 21'd42,      r: 12'd6,    z: 1'b0, lat: 21};
        vecs[7]  = '{a: 21'd0,       b: 12'd5,    q: 21'd0,       r: 12'd0,    z: 1'b0, lat: 21};
        vecs[8]  = '{a: 21'd2097151, b: 12'd1,    q: 21'd2097151, r: 12'd0,    z: 1'b0, lat: 21};
        vecs[9]  = '{a: 21'd4095,    b: 12'd4095, q: 21'd1,       r: 12'd0,    z: 1'b0, lat: 21};
        vecs[10] = '{a: 21'd2097151, b: 12'd2048, q: 21'd1023,    r: 12'd2047, z: 1'b0, lat: 21};
        vecs[11] = '{a: 21'd2097151, b: 12'd0,    q: 21'h1FFFFF,  r: 12'd4095, z: 1'b1, lat: 0};

        div_if.in_valid  = 1'b0;
        div_if.dividend  = '0;
        div_if.divisor   = '0;
        div_if.out_ready = 1'b0;
        ap_rst_n         = 1'b0;
        repeat (3) @(posedge ap_clk);
        #1;
        check("rst_in_ready",  32'(div_if.in_ready),    32'd1);
        check("rst_out_valid", 32'(div_if.out_valid),   32'd0);
        check("rst_quotient",  32'(div_if.quotient),    32'd0);
        check("rst_remainder", 32'(div_if.remainder),   32'd0);
        check("rst_dbz",       32'(div_if.div_by_zero), 32'd0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;

        // Directed table, out_ready always high.
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].a, vecs[i].b, rq, rr, rz, rlat);
            check($sformatf("vec%0d_q", i),   32'(rq),   32'(vecs[i].q));
            check($sformatf("vec%0d_r", i),   32'(rr),   32'(vecs[i].r));
            check($sformatf("vec%0d_dbz", i), 32'(rz),   32'(vecs[i].z));
            check($sformatf("vec%0d_lat", i), 32'(rlat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_idle_ready", i), 32'(div_if.in_ready),  32'd1);
            check($sformatf("vec%0d_idle_valid", i), 32'(div_if.out_valid), 32'd0);
        end

        // Backpressure: result held while out_ready is low, new operands ignored.
        @(negedge ap_clk);
        div_if.in_valid  = 1'b1;
        div_if.dividend  = 21'd300;
        div_if.divisor   = 12'd7;
        div_if.out_ready = 1'b0;
        @(posedge ap_clk);
        #1;
        div_if.in_valid = 1'b0;
        rlat = 0;
        while (!div_if.out_valid && rlat < 100) begin
            @(posedge ap_clk);
            #1;
            rlat++;
        end
        check("bp_lat", 32'(rlat), 32'd21);
        for (int i = 0; i < 10; i++) begin
            @(negedge ap_clk);
            div_if.in_valid = 1'b1;
            div_if.dividend = 21'd999;
            div_if.divisor  = 12'd0;
            check("bp_q",        32'(div_if.quotient),    32'd42);
            check("bp_r",        32'(div_if.remainder),   32'd6);
            check("bp_dbz",      32'(div_if.div_by_zero), 32'd0);
            check("bp_valid",    32'(div_if.out_valid),   32'd1);
            check("bp_in_ready", 32'(div_if.in_ready),    32'd0);
        end
        @(negedge ap_clk);
        div_if.in_valid  = 1'b0;
        div_if.out_ready = 1'b1;
        @(posedge ap_clk);
        #1;
        check("bp_release_valid", 32'(div_if.out_valid), 32'd0);
        check("bp_release_ready", 32'(div_if.in_ready),  32'd1);

        // Reset in the middle of CALC aborts the operation.
        @(negedge ap_clk);
        div_if.in_valid = 1'b1;
        div_if.dividend = 21'd1000000;
        div_if.divisor  = 12'd1000;
        @(posedge ap_clk);
        #1;
        div_if.in_valid = 1'b0;
        repeat (10) @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b0;
        #1;
        check("mrst_valid", 32'(div_if.out_valid), 32'd0);
        check("mrst_ready", 32'(div_if.in_ready),  32'd1);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        #1;
        check("mrst_rel_valid", 32'(div_if.out_valid), 32'd0);
        check("mrst_rel_ready", 32'(div_if.in_ready),  32'd1);
        run_op(21'd100, 12'd3, rq, rr, rz, rlat);
        check("mrst_q",   32'(rq),   32'd33);
        check("mrst_r",   32'(rr),   32'd1);
        check("mrst_dbz", 32'(rz),   32'd0);
        check("mrst_lat", 32'(rlat), 32'd21);

        // Random operands and random handshakes against an arithmetic reference.
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 30000 && got < NRAND; cyc++) begin
            @(negedge ap_clk);
            div_if.in_valid  = (sent < NRAND) && ($urandom_range(0, 3) != 0);
            div_if.dividend  = 21'($urandom);
            case ($urandom_range(0, 7))
                0:       div_if.divisor = 12'd0;
                1, 2:    div_if.divisor = 12'($urandom_range(1, 15));
                default: div_if.divisor = 12'($urandom);
            endcase
            div_if.out_ready = ($urandom_range(0, 2) != 0);
            #4;
            if (div_if.in_valid && div_if.in_ready) begin
                qa.push_back(div_if.dividend);
                qb.push_back(div_if.divisor);
                sent++;
            end
            if (div_if.out_valid && div_if.out_ready) begin
                got++;
                if (qa.size() == 0) begin
                    check("rand_extra_result", 32'd1, 32'd0);
                end else begin
                    ea = qa.pop_front();
                    eb = qb.pop_front();
                    if (eb == 12'd0) begin
                        eq = '1;
                        er = ea[11:0];
                        ez = 1'b1;
                    end else begin
                        eq = ea / 21'(eb);
                        er = 12'(ea % 21'(eb));
                        ez = 1'b0;
                    end
                    check("rand_q",   32'(div_if.quotient),    32'(eq));
                    check("rand_r",   32'(div_if.remainder),   32'(er));
                    check("rand_dbz", 32'(div_if.div_by_zero), 32'(ez));
                end
            end
        end
        check("rand_results", 32'(got), 32'(NRAND));
        check("rand_pending", 32'(qa.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
